// File: rtl/sent_rx_frame_decoder_pkg.sv
// Shared types and constants for the SENT receive frame decoder.
package sent_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STATUS,
    ST_DATA,
    ST_CRC,
    ST_PAUSE
  } state_e;

  localparam int unsigned CAL_TICKS = 56;
  localparam int unsigned NIB_MIN   = 12;
  localparam int unsigned NIB_MAX   = 27;
  localparam int unsigned PAUSE_MAX = 768;
  localparam logic [3:0]  CRC_SEED  = 4'd5;

  // Table for x^4+x^3+x^2+1, indexed by the running checksum.
  localparam logic [3:0] CRC_TABLE [16] = '{
    4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
    4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5
  };

  // One nibble-serial checksum step.
  function automatic logic [3:0] crc_step(input logic [3:0] crc, input logic [3:0] nib);
    return CRC_TABLE[crc] ^ nib;
  endfunction

endpackage

// File: rtl/sent_rx_frame_fifo.sv
// Synchronous frame FIFO; output reads zero while empty.
module sent_rx_frame_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             empty, rd_ok, wr_ok;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_ok  = rd_en_i && !empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign wr_ok  = wr_en_i && (!full_o || rd_ok);

  assign valid_o   = !empty;
  assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/sent_rx_frame_decoder.sv
// SENT receiver: interval timing, frame FSM, CRC check, frame buffer, error counters.
module sent_rx_frame_decoder
  import sent_rx_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = 8,
  parameter int unsigned NIBBLES      = 6,
  parameter int unsigned CRC_MODE     = 1,
  parameter int unsigned PAUSE_EN     = 1,
  parameter int unsigned CAL_TOL_CLK  = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                   clk_rx,
  input  logic                   reset_rx,
  input  logic                   data_pulse,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [3:0]             frame_status,
  output logic [4*NIBBLES-1:0]   frame_data,
  output logic [7:0]             crc_err_cnt,
  output logic [7:0]             fmt_err_cnt,
  output logic [7:0]             ovf_cnt,
  input  logic                   err_clear
);

  localparam int unsigned DW      = 4 * NIBBLES;
  localparam int unsigned CNT_MAX = 1023 * CLK_PER_TICK;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned PW      = $clog2(CLK_PER_TICK);
  localparam int unsigned CAL_CLK = CAL_TICKS * CLK_PER_TICK;
  localparam int unsigned CAL_LO  = (CAL_CLK > CAL_TOL_CLK) ? CAL_CLK - CAL_TOL_CLK : 0;
  localparam int unsigned CAL_HI  = CAL_CLK + CAL_TOL_CLK;

  // ---------------- interval timing ----------------
  logic [1:0]    sync_q;
  logic          line_prev_q, started_q;
  logic [CW-1:0] clk_cnt_q;
  logic [PW-1:0] presc_q;
  logic [9:0]    tick_q;
  logic          fall, interval_ev;

  assign fall        = line_prev_q && !sync_q[1];
  assign interval_ev = fall && started_q;

  // Synchroniser, edge detect, clock and tick counters restarted at every falling edge.
  // The prescaler tracks (clocks + CLK_PER_TICK/2) mod CLK_PER_TICK, so tick_q rounds to nearest.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      sync_q      <= '0;
      line_prev_q <= 1'b0;
      started_q   <= 1'b0;
      clk_cnt_q   <= '0;
      presc_q     <= '0;
      tick_q      <= '0;
    end else begin
      sync_q      <= {sync_q[0], data_pulse};
      line_prev_q <= sync_q[1];
      if (fall) begin
        started_q <= 1'b1;
        clk_cnt_q <= CW'(1);
        presc_q   <= PW'(CLK_PER_TICK / 2 + 1);
        tick_q    <= '0;
      end else begin
        if (clk_cnt_q != CW'(CNT_MAX)) clk_cnt_q <= clk_cnt_q + 1'b1;
        if (presc_q == PW'(CLK_PER_TICK - 1)) begin
          presc_q <= '0;
          if (tick_q != 10'd1023) tick_q <= tick_q + 1'b1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
    end
  end

  logic       is_cal, nib_ok, pause_ok;
  logic [3:0] nib;

  assign is_cal   = (clk_cnt_q >= CW'(CAL_LO)) && (clk_cnt_q <= CW'(CAL_HI));
  assign nib_ok   = (tick_q >= 10'(NIB_MIN)) && (tick_q <= 10'(NIB_MAX));
  assign pause_ok = (tick_q >= 10'(NIB_MIN)) && (tick_q <= 10'(PAUSE_MAX));
  assign nib      = 4'(tick_q - 10'(NIB_MIN));

  // ---------------- frame FSM ----------------
  state_e        state_q, state_d;
  logic [3:0]    status_q, status_d;
  logic [DW-1:0] data_q, data_d;
  logic [3:0]    crc_q, crc_d, crc_final;
  logic [2:0]    nib_cnt_q, nib_cnt_d;
  logic          pause_seen_q, pause_seen_d;
  logic          push_q, push_d;
  logic          crc_err_inc, fmt_err_inc;

  assign crc_final = (CRC_MODE != 0) ? crc_step(crc_q, 4'h0) : crc_q;

  // FSM and datapath state registers.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      state_q      <= ST_IDLE;
      status_q     <= '0;
      data_q       <= '0;
      crc_q        <= '0;
      nib_cnt_q    <= '0;
      pause_seen_q <= 1'b0;
      push_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      data_q       <= data_d;
      crc_q        <= crc_d;
      nib_cnt_q    <= nib_cnt_d;
      pause_seen_q <= pause_seen_d;
      push_q       <= push_d;
    end
  end

  // Next-state decode, evaluated once per completed interval.
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    data_d       = data_q;
    crc_d        = crc_q;
    nib_cnt_d    = nib_cnt_q;
    pause_seen_d = pause_seen_q;
    push_d       = 1'b0;
    crc_err_inc  = 1'b0;
    fmt_err_inc  = 1'b0;
    if (interval_ev) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_cal) begin
            state_d = ST_STATUS;
            crc_d   = CRC_SEED;
          end
        end
        ST_STATUS: begin
          if (nib_ok) begin
            status_d  = nib;
            nib_cnt_d = '0;
            state_d   = ST_DATA;
          end else begin
            fmt_err_inc = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (nib_ok) begin
            data_d = (data_q << 4) | DW'(nib);
            crc_d  = crc_step(crc_q, nib);
            if (nib_cnt_q == 3'(NIBBLES - 1)) state_d = ST_CRC;
            else nib_cnt_d = nib_cnt_q + 1'b1;
          end else begin
            fmt_err_inc = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        ST_CRC: begin
          if (nib_ok) begin
            state_d      = ST_PAUSE;
            pause_seen_d = 1'b0;
            if (nib == crc_final) push_d = 1'b1;
            else crc_err_inc = 1'b1;
          end else begin
            fmt_err_inc = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          if (is_cal) begin
            state_d = ST_STATUS;
            crc_d   = CRC_SEED;
          end else if ((PAUSE_EN != 0) && pause_ok && !pause_seen_q) begin
            pause_seen_d = 1'b1;
          end else begin
            fmt_err_inc = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- frame buffer ----------------
  logic          fifo_full, pop;
  logic [DW+3:0] head;

  assign pop = frame_valid && frame_ready;

  sent_rx_frame_fifo #(
    .WIDTH (DW + 4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_rx),
    .rst_i     (reset_rx),
    .wr_en_i   (push_q),
    .wr_data_i ({status_q, data_q}),
    .rd_en_i   (frame_ready),
    .rd_data_o (head),
    .valid_o   (frame_valid),
    .full_o    (fifo_full)
  );

  assign frame_status = head[DW+3:DW];
  assign frame_data   = head[DW-1:0];

  // ---------------- error counters ----------------
  logic [7:0] crc_err_q, fmt_err_q, ovf_q;
  logic       ovf_inc;

  assign ovf_inc = push_q && fifo_full && !pop;

  // Saturating counters; err_clear wins over a same-cycle increment.
  always_ff @(posedge clk_rx) begin
    if (reset_rx || err_clear) begin
      crc_err_q <= '0;
      fmt_err_q <= '0;
      ovf_q     <= '0;
    end else begin
      if (crc_err_inc && crc_err_q != 8'hFF) crc_err_q <= crc_err_q + 1'b1;
      if (fmt_err_inc && fmt_err_q != 8'hFF) fmt_err_q <= fmt_err_q + 1'b1;
      if (ovf_inc     && ovf_q     != 8'hFF) ovf_q     <= ovf_q + 1'b1;
    end
  end

  assign crc_err_cnt = crc_err_q;
  assign fmt_err_cnt = fmt_err_q;
  assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_sent_rx_frame_decoder.sv
// Directed scoreboard bench for sent_rx_frame_decoder at default parameters,
// plus a CRC_MODE=0 instance sharing the same line.
module tb_sent_rx_frame_decoder;

  localparam int CPT = 8;

  logic        clk = 1'b0;
  logic        rst, dpulse, ready, err_clear;
  logic        valid, valid0;
  logic [3:0]  status, status0;
  logic [23:0] data, data0;
  logic [7:0]  crc_cnt, fmt_cnt, ovf_cnt, crc_cnt0, fmt_cnt0, ovf_cnt0;

  always #5 clk = ~clk;

  sent_rx_frame_decoder #(
    .CLK_PER_TICK (8),
    .NIBBLES      (6),
    .CRC_MODE     (1),
    .PAUSE_EN     (1),
    .CAL_TOL_CLK  (16),
    .FIFO_DEPTH   (4)
  ) u_dut (
    .clk_rx       (clk),
    .reset_rx     (rst),
    .data_pulse   (dpulse),
    .frame_valid  (valid),
    .frame_ready  (ready),
    .frame_status (status),
    .frame_data   (data),
    .crc_err_cnt  (crc_cnt),
    .fmt_err_cnt  (fmt_cnt),
    .ovf_cnt      (ovf_cnt),
    .err_clear    (err_clear)
  );

  sent_rx_frame_decoder #(
    .CRC_MODE (0)
  ) u_dut0 (
    .clk_rx       (clk),
    .reset_rx     (rst),
    .data_pulse   (dpulse),
    .frame_valid  (valid0),
    .frame_ready  (1'b0),
    .frame_status (status0),
    .frame_data   (data0),
    .crc_err_cnt  (crc_cnt0),
    .fmt_err_cnt  (fmt_cnt0),
    .ovf_cnt      (ovf_cnt0),
    .err_clear    (err_clear)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [27:0] sb[$];
  logic [27:0] exp_frame;

  localparam logic [3:0] TBL [16] = '{
    4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
    4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5
  };

  function automatic logic [3:0] model_crc(input logic [23:0] d, input bit aug);
    logic [3:0] c;
    c = 4'd5;
    for (int i = 0; i < 6; i++) c = TBL[c] ^ d[23-4*i -: 4];
    if (aug) c = TBL[c];
    return c;
  endfunction

  function automatic int nibclk(input logic [3:0] v);
    return (12 + int'(v)) * CPT;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Falling edge now, low for 32 clocks, next falling edge after 'clocks'.
  task automatic drive_interval(input int clocks);
    dpulse = 1'b0;
    repeat (32) @(negedge clk);
    dpulse = 1'b1;
    repeat (clocks - 32) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] st, input logic [23:0] d, input logic [3:0] crc,
                            input int cal_clk, input int bad_idx, input int bad_clk);
    drive_interval(cal_clk);
    drive_interval(nibclk(st));
    for (int i = 0; i < 6; i++)
      drive_interval((i == bad_idx) ? bad_clk : nibclk(d[23-4*i -: 4]));
    drive_interval(nibclk(crc));
    drive_interval(800);
  endtask

  task automatic good_frame(input logic [3:0] st, input logic [23:0] d, input bit expect_push);
    if (expect_push) sb.push_back({st, d});
    send_frame(st, d, model_crc(d, 1'b1), 448, -1, 0);
  endtask

  task automatic pop_check(input string tag);
    int waited;
    waited = 0;
    while (!valid && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      exp_frame = sb.pop_front();
      check({tag, "_status"}, {28'd0, status}, {28'd0, exp_frame[27:24]});
      check({tag, "_data"}, {8'd0, data}, {8'd0, exp_frame[23:0]});
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dpulse = 1'b1; ready = 1'b0; err_clear = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_valid",   {31'd0, valid}, 32'd0);
    check("rst_status",  {28'd0, status}, 32'd0);
    check("rst_data",    {8'd0, data}, 32'd0);
    check("rst_crc_cnt", {24'd0, crc_cnt}, 32'd0);
    check("rst_fmt_cnt", {24'd0, fmt_cnt}, 32'd0);
    check("rst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);

    // All-zero frame, CRC 5 under augmentation.
    sb.push_back(28'h0);
    send_frame(4'h0, 24'h000000, 4'd5, 448, -1, 0);
    pop_check("zero_frame");
    check("zero_crc_cnt", {24'd0, crc_cnt}, 32'd0);

    good_frame(4'hA, 24'h123456, 1'b1);
    pop_check("frame_123456");
    check("b_fmt_cnt", {24'd0, fmt_cnt}, 32'd0);

    // Legacy checksum value: rejected here, accepted by the CRC_MODE=0 instance.
    send_frame(4'h0, 24'h000000, 4'd15, 448, -1, 0);
    check("badcrc_valid", {31'd0, valid}, 32'd0);
    check("badcrc_cnt", {24'd0, crc_cnt}, 32'd1);
    check("mode0_valid", {31'd0, valid0}, 32'd1);
    check("mode0_data", {8'd0, data0}, 32'd0);

    // Calibration 22 clocks off: in PAUSE after a pause this is a format error.
    send_frame(4'h3, 24'hFEDCBA, model_crc(24'hFEDCBA, 1'b1), 470, -1, 0);
    check("cal470_valid", {31'd0, valid}, 32'd0);
    check("cal470_fmt", {24'd0, fmt_cnt}, 32'd1);

    sb.push_back({4'h3, 24'hFEDCBA});
    send_frame(4'h3, 24'hFEDCBA, model_crc(24'hFEDCBA, 1'b1), 462, -1, 0);
    pop_check("cal462");

    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
    check("clr_crc_cnt", {24'd0, crc_cnt}, 32'd0);
    check("clr_fmt_cnt", {24'd0, fmt_cnt}, 32'd0);

    // 28-tick data interval aborts the frame.
    send_frame(4'h1, 24'h777777, model_crc(24'h777777, 1'b1), 448, 2, 224);
    check("long_nib_valid", {31'd0, valid}, 32'd0);
    check("long_nib_fmt", {24'd0, fmt_cnt}, 32'd1);

    good_frame(4'h5, 24'h0A5A5A, 1'b1);
    pop_check("after_abort");

    // Five frames into a 4-deep buffer with no consumer.
    for (int k = 1; k <= 5; k++)
      good_frame(4'(k), {6{4'(k)}}, k <= 4);
    check("ovf_cnt", {24'd0, ovf_cnt}, 32'd1);
    check("ovf_head_status", {28'd0, status}, {28'd0, sb[0][27:24]});
    check("ovf_head_data", {8'd0, data}, {8'd0, sb[0][23:0]});
    for (int k = 0; k < 4; k++) pop_check("ovf_drain");
    check("ovf_empty", {31'd0, valid}, 32'd0);

    // Reset part-way through data nibble 3, then one clean frame.
    drive_interval(448);
    drive_interval(nibclk(4'h2));
    drive_interval(nibclk(4'h1));
    drive_interval(nibclk(4'h2));
    drive_interval(nibclk(4'h3));
    dpulse = 1'b0;
    repeat (32) @(negedge clk);
    dpulse = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_ovf", {24'd0, ovf_cnt}, 32'd0);
    good_frame(4'h9, 24'hC0FFEE, 1'b1);
    pop_check("post_rst");
    @(negedge clk);
    check("post_rst_empty", {31'd0, valid}, 32'd0);
    check("post_rst_crc", {24'd0, crc_cnt}, 32'd0);
    check("post_rst_fmt", {24'd0, fmt_cnt}, 32'd0);
    check("post_rst_ovf", {24'd0, ovf_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
